// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter; byte FIFO feeding an 8N1 serialiser on tx_o.
// Latency: a push at edge N into an idle, empty block is popped and drives the start bit at edge N+1.
// Backpressure: none on the bus; a push into a full FIFO is dropped and latches sticky overflow.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0010,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  dbus_en_i,
  input  logic [31:0] dbus_write_addr_i,
  input  logic [31:0] dbus_write_data_i,
  input  logic [31:0] dbus_read_addr_i,
  output logic        sel_o,
  output logic [31:0] rdata_o,
  output logic        tx_o
);

  localparam logic [31:0]   CTRL_ADDR  = BASE_ADDR + 32'd4;
  localparam int            AW         = $clog2(FIFO_DEPTH);
  localparam int            PW         = AW + 1;
  localparam int            CW         = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] FULL_COUNT = PW'(FIFO_DEPTH);

  // Elaboration-time sanity checks on the configuration.
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_mmio: CLKS_PER_BIT must be >= 2");
  end
  if ((FIFO_DEPTH < 2) || ((1 << AW) != FIFO_DEPTH)) begin : g_bad_depth
    $error("uart_tx_mmio: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  // ---------------------------------------------------------------
  // Bus write decode
  // ---------------------------------------------------------------
  logic data_wr;
  logic ovf_clr;
  logic unused_bus_bits;

  assign data_wr = dbus_en_i[0] && (dbus_write_addr_i == BASE_ADDR);
  assign ovf_clr = dbus_en_i[0] && (dbus_write_addr_i == CTRL_ADDR) && dbus_write_data_i[2];

  // Only byte lane 0 carries anything meaningful for this peripheral.
  assign unused_bus_bits = ^{dbus_en_i[3:1], dbus_write_data_i[31:8]};

  // ---------------------------------------------------------------
  // TX FIFO: pointers carry one extra wrap bit so the count reaches FIFO_DEPTH
  // ---------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic          push;
  logic          drop;
  logic          pop;
  logic          ovf;

  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_full  = (fifo_count == FULL_COUNT);
  assign fifo_empty = (fifo_count == '0);
  assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

  // Fullness is judged before any same-cycle pop, so a push into a full FIFO is always dropped.
  assign push = data_wr && !fifo_full;
  assign drop = data_wr && fifo_full;

  // Storage array; unreset because only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= dbus_write_data_i[7:0];
    end
  end

  // Pointer advance on accepted push and on serialiser pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf <= 1'b0;
    end else begin
      ovf <= (ovf && !ovf_clr) || drop;
    end
  end

  // ---------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] baud_cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    bit_idx;
  logic [2:0]    idx_n;
  logic [7:0]    shift_q;
  logic [7:0]    shift_n;
  logic          tx_q;
  logic          tx_n;
  logic          bit_done;
`ifdef UART_TX_PARITY_EN
  logic          par_q;
  logic          par_n;
`endif

  // The current line level has been held for CLKS_PER_BIT cycles once the counter reaches zero.
  assign bit_done = (baud_cnt == '0);

  // State, counters, shifter and the registered line level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      baud_cnt <= cnt_n;
      bit_idx  <= idx_n;
      shift_q  <= shift_n;
      tx_q     <= tx_n;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_n;
`endif
    end
  end

  // Next-state logic; tx_n is the level for the state being entered, so tx_o changes on the entry edge.
  always_comb begin
    state_n = state;
    cnt_n   = bit_done ? baud_cnt : (baud_cnt - CW'(1));
    idx_n   = bit_idx;
    shift_n = shift_q;
    tx_n    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif
    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_head;
          cnt_n   = BIT_RELOAD;
          tx_n    = 1'b0;
          state_n = S_START;
`ifdef UART_TX_PARITY_EN
          par_n   = ^fifo_head;
`endif
        end
      end
      S_START: begin
        if (bit_done) begin
          state_n = S_DATA;
          cnt_n   = BIT_RELOAD;
          idx_n   = 3'd0;
          tx_n    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_n = BIT_RELOAD;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
            tx_n    = par_q;
`else
            state_n = S_STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            idx_n   = bit_idx + 3'd1;
            shift_n = {1'b0, shift_q[7:1]};
            tx_n    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          state_n = S_STOP;
          cnt_n   = BIT_RELOAD;
          tx_n    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            // Chain straight into the next start bit with no idle gap.
            pop     = 1'b1;
            shift_n = fifo_head;
            cnt_n   = BIT_RELOAD;
            tx_n    = 1'b0;
            state_n = S_START;
`ifdef UART_TX_PARITY_EN
            par_n   = ^fifo_head;
`endif
          end else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  assign tx_o = tx_q;

  // ---------------------------------------------------------------
  // Combinational read port
  // ---------------------------------------------------------------
  logic [31:0] status;

  // Status word: done, full, overflow and the FIFO occupancy.
  always_comb begin
    status       = '0;
    status[0]    = fifo_empty && (state == S_IDLE);
    status[1]    = fifo_full;
    status[2]    = ovf;
    status[15:8] = 8'(fifo_count);
  end

  assign sel_o   = (dbus_read_addr_i == BASE_ADDR) || (dbus_read_addr_i == CTRL_ADDR);
  assign rdata_o = (dbus_read_addr_i == CTRL_ADDR) ? status : 32'd0;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: randomized bench for uart_tx_mmio with a line-level reference model.
// Latency: not applicable.
// Backpressure: not applicable.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE  = 32'h8000_0010;
  localparam logic [31:0] CTRL  = 32'h8000_0014;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int          NBITS = 11;
`else
  localparam int          NBITS = 10;
`endif
  localparam int          FL    = NBITS * CPB;

  logic        clk_i             = 1'b0;
  logic        rst_i             = 1'b1;
  logic [3:0]  dbus_en_i         = 4'd0;
  logic [31:0] dbus_write_addr_i = 32'd0;
  logic [31:0] dbus_write_data_i = 32'd0;
  logic [31:0] dbus_read_addr_i  = CTRL;
  logic        sel_o;
  logic [31:0] rdata_o;
  logic        tx_o;

  int          vectors     = 0;
  int          miscompares = 0;
  int          rst_cnt     = 0;
  logic [7:0]  wq[$];
  logic [9:0]  rx_q[$];

  uart_tx_mmio #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .dbus_en_i        (dbus_en_i),
    .dbus_write_addr_i(dbus_write_addr_i),
    .dbus_write_data_i(dbus_write_data_i),
    .dbus_read_addr_i (dbus_read_addr_i),
    .sel_o            (sel_o),
    .rdata_o          (rdata_o),
    .tx_o             (tx_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge rst_i) rst_cnt++;

  // Expected line level t cycles after the start bit begins, for byte b.
  function automatic logic model_line(input logic [7:0] b, input int t);
    int k;
    k = t / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Expected decoded frame: {parity, stop, data}.
  function automatic logic [9:0] exp_rx(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {^b, 1'b1, b};
`else
    return {1'b0, 1'b1, b};
`endif
  endfunction

  // Line decoder: samples mid-bit and queues every complete frame not cut by reset.
  initial begin : monitor
    int         start_rst;
    logic [7:0] b;
    logic       p;
    logic       s;
    forever begin
      @(negedge clk_i);
      if (!rst_i && tx_o === 1'b0) begin
        start_rst = rst_cnt;
        b = 8'd0;
        p = 1'b0;
        repeat (CPB / 2) @(negedge clk_i);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk_i);
          b[k] = tx_o;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk_i);
        p = tx_o;
`endif
        repeat (CPB) @(negedge clk_i);
        s = tx_o;
        repeat (CPB - CPB / 2 - 1) @(negedge clk_i);
        if (rst_cnt == start_rst) rx_q.push_back({p, s, b});
      end
    end
  end

  // Writes every byte of wq on consecutive cycles; returns at the negedge after the last capture.
  task automatic drive_writes();
    foreach (wq[k]) begin
      @(negedge clk_i);
      dbus_en_i         = {3'($urandom), 1'b1};
      dbus_write_addr_i = BASE;
      dbus_write_data_i = {24'($urandom), wq[k]};
    end
    @(negedge clk_i);
    dbus_en_i = 4'd0;
  endtask

  task automatic ctrl_write(input logic [3:0] en, input logic [31:0] d);
    @(negedge clk_i);
    dbus_en_i         = en;
    dbus_write_addr_i = CTRL;
    dbus_write_data_i = d;
    @(negedge clk_i);
    dbus_en_i = 4'd0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk_i);
      if (rdata_o[0] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i            = 1'b1;
    dbus_en_i        = 4'd0;
    dbus_read_addr_i = 32'h0000_1000;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    vectors++;
    if (tx_o !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", tx_o); end
    vectors++;
    if (sel_o !== 1'b0) begin miscompares++; $display("FAIL reset_sel_other: got %b want 0", sel_o); end
    vectors++;
    if (rdata_o !== 32'd0) begin miscompares++; $display("FAIL reset_rdata_other: got %h want 0", rdata_o); end
    dbus_read_addr_i = CTRL;
    #1;
    vectors++;
    if (sel_o !== 1'b1) begin miscompares++; $display("FAIL reset_sel_ctrl: got %b want 1", sel_o); end
    vectors++;
    if (rdata_o !== 32'h0000_0001) begin miscompares++; $display("FAIL reset_status: got %h want 00000001", rdata_o); end
    dbus_read_addr_i = BASE;
    #1;
    vectors++;
    if (sel_o !== 1'b1 || rdata_o !== 32'd0) begin
      miscompares++; $display("FAIL data_reg_read: got sel=%b rdata=%h want sel=1 rdata=0", sel_o, rdata_o);
    end
    dbus_read_addr_i = CTRL;
  endtask

  task automatic test_decode();
    rx_q.delete();
    @(negedge clk_i);
    dbus_en_i = 4'b1110; dbus_write_addr_i = BASE; dbus_write_data_i = $urandom;
    @(negedge clk_i);
    dbus_en_i = 4'b0001; dbus_write_addr_i = BASE + 32'd8;
    @(negedge clk_i);
    dbus_write_addr_i = BASE - 32'd4;
    @(negedge clk_i);
    dbus_en_i = 4'd0;
    repeat (2) @(negedge clk_i);
    vectors++;
    if (rdata_o !== 32'h0000_0001 || tx_o !== 1'b1) begin
      miscompares++; $display("FAIL decode_no_push: got status=%h tx=%b want 00000001/1", rdata_o, tx_o);
    end
  endtask

  task automatic test_single();
    logic [7:0] pats[4];
    pats[0] = 8'h55; pats[1] = 8'h07; pats[2] = 8'($urandom); pats[3] = 8'($urandom);
    for (int p = 0; p < 4; p++) begin
      rx_q.delete(); wq.delete();
      wq.push_back(pats[p]);
      drive_writes();
      vectors++;
      if (rdata_o !== 32'h0000_0100 || tx_o !== 1'b1) begin
        miscompares++; $display("FAIL single_after_push %h: got status=%h tx=%b want 00000100/1", pats[p], rdata_o, tx_o);
      end
      for (int i = 0; i < FL; i++) begin
        @(negedge clk_i);
        vectors++;
        if (tx_o !== model_line(pats[p], i)) begin
          miscompares++; $display("FAIL single_line %h cyc %0d: got %b want %b", pats[p], i, tx_o, model_line(pats[p], i));
        end
      end
      vectors++;
      if (rdata_o !== 32'd0) begin miscompares++; $display("FAIL single_last_stop_status: got %h want 0", rdata_o); end
      @(negedge clk_i);
      vectors++;
      if (rdata_o !== 32'h0000_0001) begin miscompares++; $display("FAIL single_done: got %h want 00000001", rdata_o); end
      vectors++;
      if (rx_q.size() != 1 || rx_q[0] !== exp_rx(pats[p])) begin
        miscompares++; $display("FAIL single_rx: got n=%0d first=%h want n=1 %h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 10'h0, exp_rx(pats[p]));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] b;
    for (int p = 0; p < 2; p++) begin
      a = (p == 0) ? 8'hA1 : 8'($urandom);
      b = (p == 0) ? 8'h3C : 8'($urandom);
      rx_q.delete(); wq.delete();
      wq.push_back(a); wq.push_back(b);
      drive_writes();
      vectors++;
      if (rdata_o !== 32'h0000_0100) begin miscompares++; $display("FAIL b2b_status: got %h want 00000100", rdata_o); end
      for (int i = 0; i < 2 * FL; i++) begin
        if (i > 0) @(negedge clk_i);
        vectors++;
        if (tx_o !== model_line((i < FL) ? a : b, i % FL)) begin
          miscompares++; $display("FAIL b2b_line cyc %0d: got %b want %b", i, tx_o, model_line((i < FL) ? a : b, i % FL));
        end
      end
      @(negedge clk_i);
      vectors++;
      if (rdata_o !== 32'h0000_0001) begin miscompares++; $display("FAIL b2b_done: got %h want 00000001", rdata_o); end
      vectors++;
      if (rx_q.size() != 2 || rx_q[0] !== exp_rx(a) || rx_q[1] !== exp_rx(b)) begin
        miscompares++; $display("FAIL b2b_rx: got n=%0d want 2 frames %h %h", rx_q.size(), exp_rx(a), exp_rx(b));
      end
    end
  endtask

  task automatic test_overflow();
    int          n_acc;
    logic [31:0] exp_status;
    bit          ok;
    rx_q.delete(); wq.delete();
    for (int k = 0; k < DEPTH + 2; k++) wq.push_back(8'($urandom));
    drive_writes();
    // One byte is already in the shifter; DEPTH more fit in the FIFO; the rest are dropped.
    n_acc      = (wq.size() < DEPTH + 1) ? wq.size() : DEPTH + 1;
    exp_status = 32'(((n_acc - 1) << 8) | ((wq.size() > n_acc) ? 4 : 0) | ((n_acc - 1 == DEPTH) ? 2 : 0));
    vectors++;
    if (rdata_o !== exp_status) begin miscompares++; $display("FAIL ovf_status: got %h want %h", rdata_o, exp_status); end
    wait_idle(FL * (DEPTH + 2) + 50, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL ovf_drain_timeout: got busy want done"); end
    vectors++;
    if (rx_q.size() != n_acc) begin miscompares++; $display("FAIL ovf_rx_count: got %0d want %0d", rx_q.size(), n_acc); end
    for (int k = 0; k < n_acc; k++) begin
      vectors++;
      if (k >= rx_q.size() || rx_q[k] !== exp_rx(wq[k])) begin
        miscompares++; $display("FAIL ovf_rx_byte %0d: got %h want %h", k, (k < rx_q.size()) ? rx_q[k] : 10'h0, exp_rx(wq[k]));
      end
    end
    vectors++;
    if (rdata_o !== 32'h0000_0005) begin miscompares++; $display("FAIL ovf_sticky: got %h want 00000005", rdata_o); end
  endtask

  task automatic test_overflow_clear();
    ctrl_write(4'b1110, 32'h4 | $urandom);
    vectors++;
    if (rdata_o !== 32'h0000_0005) begin miscompares++; $display("FAIL clr_no_en0: got %h want 00000005", rdata_o); end
    ctrl_write(4'b0001, $urandom & ~32'h4);
    vectors++;
    if (rdata_o !== 32'h0000_0005) begin miscompares++; $display("FAIL clr_bit2_low: got %h want 00000005", rdata_o); end
    ctrl_write({3'($urandom), 1'b1}, 32'h4);
    vectors++;
    if (rdata_o !== 32'h0000_0001) begin miscompares++; $display("FAIL clr_bit2: got %h want 00000001", rdata_o); end
  endtask

  task automatic test_drop_at_pop();
    bit ok;
    rx_q.delete(); wq.delete();
    for (int k = 0; k < DEPTH + 1; k++) wq.push_back(8'($urandom));
    drive_writes();
    vectors++;
    if (rdata_o !== 32'((DEPTH << 8) | 2)) begin
      miscompares++; $display("FAIL dap_full: got %h want %h", rdata_o, 32'((DEPTH << 8) | 2));
    end
    // Land one more push on the edge that ends the first frame and pops the FIFO.
    repeat (FL - DEPTH) @(negedge clk_i);
    dbus_en_i = 4'b0001; dbus_write_addr_i = BASE; dbus_write_data_i = $urandom;
    @(negedge clk_i);
    dbus_en_i = 4'd0;
    vectors++;
    if (tx_o !== 1'b0) begin miscompares++; $display("FAIL dap_next_start: got %b want 0", tx_o); end
    vectors++;
    if (rdata_o !== 32'(((DEPTH - 1) << 8) | 4)) begin
      miscompares++; $display("FAIL dap_dropped: got %h want %h", rdata_o, 32'(((DEPTH - 1) << 8) | 4));
    end
    wait_idle(FL * (DEPTH + 2), ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL dap_drain_timeout: got busy want done"); end
    vectors++;
    if (rx_q.size() != DEPTH + 1) begin miscompares++; $display("FAIL dap_rx_count: got %0d want %0d", rx_q.size(), DEPTH + 1); end
    for (int k = 0; k < DEPTH + 1; k++) begin
      vectors++;
      if (k >= rx_q.size() || rx_q[k] !== exp_rx(wq[k])) begin
        miscompares++; $display("FAIL dap_rx_byte %0d: got %h want %h", k, (k < rx_q.size()) ? rx_q[k] : 10'h0, exp_rx(wq[k]));
      end
    end
    ctrl_write(4'b0001, 32'h4);
    vectors++;
    if (rdata_o !== 32'h0000_0001) begin miscompares++; $display("FAIL dap_clear: got %h want 00000001", rdata_o); end
  endtask

  task automatic test_random_stream();
    logic [7:0] exp_q[$];
    bit         ok;
    rx_q.delete();
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, FL)) @(negedge clk_i);
      wq.delete();
      wq.push_back(8'($urandom));
      exp_q.push_back(wq[0]);
      drive_writes();
    end
    wait_idle(8 * FL + 50, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rand_timeout: got busy want done"); end
    vectors++;
    if (rx_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rand_rx_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      vectors++;
      if (k >= rx_q.size() || rx_q[k] !== exp_rx(exp_q[k])) begin
        miscompares++; $display("FAIL rand_rx_byte %0d: got %h want %h", k, (k < rx_q.size()) ? rx_q[k] : 10'h0, exp_rx(exp_q[k]));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int low_cycles;
    rx_q.delete(); wq.delete();
    for (int k = 0; k < 4; k++) wq.push_back(8'($urandom));
    drive_writes();
    vectors++;
    if (rdata_o !== 32'h0000_0300) begin miscompares++; $display("FAIL mid_queued: got %h want 00000300", rdata_o); end
    repeat (10) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    vectors++;
    if (tx_o !== 1'b1) begin miscompares++; $display("FAIL mid_rst_tx: got %b want 1", tx_o); end
    vectors++;
    if (rdata_o !== 32'h0000_0001) begin miscompares++; $display("FAIL mid_rst_status: got %h want 00000001", rdata_o); end
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    low_cycles = 0;
    for (int c = 0; c < 3 * FL; c++) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) low_cycles++;
    end
    vectors++;
    if (low_cycles != 0) begin miscompares++; $display("FAIL mid_line_idle: got %0d low cycles want 0", low_cycles); end
    vectors++;
    if (rx_q.size() != 0) begin miscompares++; $display("FAIL mid_no_frames: got %0d frames want 0", rx_q.size()); end
    vectors++;
    if (rdata_o !== 32'h0000_0001) begin miscompares++; $display("FAIL mid_final_status: got %h want 00000001", rdata_o); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_single();
    test_back_to_back();
    test_overflow();
    test_overflow_clear();
    test_drop_at_pop();
    test_random_stream();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
